// File: rtl/mips_bus_memory.sv
// Word-organised memory slave for the mips_cpu_bus interface: programmable wait
// states, byte-lane writes, sticky bus error on illegal or malformed accesses.
module mips_bus_memory #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1,
  localparam int unsigned IW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   address,
  input  logic          read,
  input  logic          write,
  input  logic [31:0]   writedata,
  input  logic [3:0]    byteenable,
  output logic          waitrequest,
  output logic [31:0]   readdata,
  output logic          bus_error,
  input  logic [IW-1:0] dbg_index,
  output logic [31:0]   dbg_word
);

  localparam int unsigned CW       = 4;
  localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic {IDLE, STALL} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            req;
  logic            commit_c;
  logic            wait_c;
  logic [31:0]     word_off;
  logic            legal;
  logic [IW-1:0]   idx;
  logic [31:0]     mem [DEPTH];

  assign req      = read | write;
  assign word_off = 32'((address - BASE_ADDR) >> 2);
  assign legal    = (address[1:0] == 2'b00) && (word_off < 32'(DEPTH));
  assign idx      = word_off[IW-1:0];
  assign dbg_word = mem[dbg_index];

  // waitrequest is combinational by protocol and forced low while in reset
  assign waitrequest = wait_c & ~reset;

  // State and wait-state counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, stall and commit decision
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    commit_c   = 1'b0;
    wait_c     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (NO_WAIT) begin
            commit_c = 1'b1;
          end else begin
            wait_c     = 1'b1;
            cnt_next   = CNT_LOAD;
            state_next = STALL;
          end
        end
      end
      STALL: begin
        if (!req) begin
          state_next = IDLE;
        end else if (cnt != '0) begin
          wait_c   = 1'b1;
          cnt_next = cnt - CW'(1);
        end else begin
          commit_c   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Read data and sticky error; address 0 is the CPU's idle fetch and never errors
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata  <= '0;
      bus_error <= 1'b0;
    end else if (commit_c) begin
      if (read && write) begin
        bus_error <= 1'b1;
      end else if (read) begin
        if (address == 32'd0) begin
          readdata <= '0;
        end else if (legal) begin
          readdata <= mem[idx];
        end else begin
          readdata  <= '0;
          bus_error <= 1'b1;
        end
      end else if (address != 32'd0 && !legal) begin
        bus_error <= 1'b1;
      end
    end
  end

  // Byte-lane write port; the array is deliberately left untouched by reset
  always_ff @(posedge clk) begin
    if (!reset && commit_c && write && !read && address != 32'd0 && legal) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

endmodule
